sfx_scheduler: RTL and testbench
================================

# sfx_scheduler

Sequences the sound-effect voices that feed the 8-channel audio mixer. Shares one synchronous sample ROM among 8 channels with a fixed round-robin sweep once per sample tick. Drives per-channel sample words, updated atomically, straight into the mixer's `channel_1..channel_8` inputs. Accepts trigger and stop requests from the game logic and reports per-channel busy status.

## Interface
- `WIDTH`, 8: sample word width; equals mixer `WIDTH`.
- `CHANNELS`, 8: number of voices; fixed at 8 to match the mixer.
- `ADDR_W`, 12: sample ROM address width.
- `TICK_DIV`, 3125: clk cycles per sample tick; must be at least `CHANNELS+3`.

- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in `CHANNELS`: per-channel start request; level sampled each cycle, and any high cycle latches a pending start.
- `stop` in `CHANNELS`: per-channel stop request; latched like `trigger`.
- `loop` in `CHANNELS`: per-channel loop enable. Present only with `SFX_LOOP_EN`.
- `rom_en` out 1: ROM read strobe.
- `rom_addr` out `ADDR_W`: ROM address.
- `rom_data` in `WIDTH`: ROM data, valid exactly 1 cycle after `rom_en`.
- `ch_data` out `CHANNELS*WIDTH`: channel samples; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `busy` out `CHANNELS`: channel currently playing.
- `sample_valid` out 1: 1-cycle pulse when `ch_data` has just been committed.

## Operation
- **Tick generation:** a free-running divider counts 0..`TICK_DIV-1`. A tick is asserted when the count wraps.
- **State machine:** IDLE → SWEEP → DRAIN → COMMIT → IDLE.
  - **IDLE:** wait for a tick. On the tick, apply pending requests:
    - stop pending: clear busy; stop wins over a trigger pending in the same sweep.
    - trigger pending (no stop): set busy and reset that channel's offset to 0. This also covers a retrigger of a busy channel.
    - Clear all pending bits.
  - **SWEEP:** slot counter s = 0..`CHANNELS-1`, one slot per cycle.
    - If `busy[s]`: `rom_en`=1 and `rom_addr = SFX_BASE[s] + offset[s]`.
    - Otherwise `rom_en`=0.
  - **Capture:** each cycle, the slot from the previous cycle is captured.
    - Busy slot: shadow[s] ← `rom_data`, then offset advances.
    - Idle slot: shadow[s] ← 0 (silence).
  - **End of sound:** when a captured offset equals `SFX_LEN[s]-1`, the channel ends. busy[s] clears in the same cycle, offset returns to 0, and the last sample is still committed.
  - **DRAIN:** captures the last slot.
  - **COMMIT:** `ch_data` ← all shadows at once; `sample_valid`=1.
- **Request capture:** `trigger` or `stop` that arrives during SWEEP, DRAIN or COMMIT stays pending until the next tick. No request is lost.
- **Widths:**
  - `offset` is `ADDR_W` bits.
  - `SFX_BASE + offset` is truncated to `ADDR_W` bits; table entries must not overflow.
  - `SFX_LEN` of 0 is illegal.

## Timing
- Tick at cycle T:
  - SWEEP runs T+1..T+8, with addresses for channels 0..7 in order.
  - Data is captured T+2..T+9.
  - COMMIT and `sample_valid` at T+10.
- A tick can never arrive outside IDLE, given `TICK_DIV` ≥ `CHANNELS+3`.
- Trigger to first audible sample: committed at the first COMMIT after the next tick.
- `busy` changes only at the tick (start or stop) or at capture (end of sound).
- **Reset values:**
  - `ch_data`=0, `busy`=0, `sample_valid`=0, `rom_en`=0, `rom_addr`=0.
  - Divider=0, all offsets and pending bits cleared, state IDLE.
- **Reset mid-sweep:** everything returns to reset values immediately. No partial commit occurs.

## Configuration
- `SFX_LOOP_EN` defined:
  - The `loop` port exists.
  - If `loop[s]`=1 when a channel reaches `SFX_LEN[s]-1`, offset wraps to 0 and busy stays set.
  - Only a stop request ends a looping channel.
- Not defined:
  - No `loop` port.
  - Every channel is one-shot.

## Structure
- Shared package `audio_pkg` holds:
  - `SFX_BASE[0..7]` and `SFX_LEN[0..7]` constant tables;
  - the state enum (IDLE, SWEEP, DRAIN, COMMIT);
  - the `CHANNELS` constant shared with the mixer instance.
- One sub-module, `sample_tick_gen` (parameter `TICK_DIV`; outputs 1-cycle `tick`), reusable by other audio blocks.

## Test plan
- **One-shot:** `TICK_DIV`=16, `SFX_LEN[0]`=4, `trigger[0]` pulse → four successive `sample_valid` show ch0 = ROM[base0..base0+3]. The fifth shows 0, and `busy[0]` falls at the fourth capture.
- **All channels:** all 8 triggered in one cycle → within one sweep `rom_addr` = `SFX_BASE[0]`..`SFX_BASE[7]` on consecutive cycles. `sample_valid` fires 10 cycles after the tick.
- **Retrigger:** retrigger ch2 at offset 5 → the next sweep addresses `SFX_BASE[2]+0`.
- **Trigger/stop collision:** `trigger[3]` and `stop[3]` in the same cycle on an idle channel → `busy[3]` stays 0 and ch3 output stays 0.
- **Reset mid-sweep:** `rst` asserted at T+4 → `ch_data`=0, `busy`=0, `rom_en`=0 immediately. After release the first tick comes `TICK_DIV` cycles later.
- **Loop (with `SFX_LOOP_EN`):** `loop[1]`=1, `SFX_LEN[1]`=3 → addresses base1, base1+1, base1+2, base1 … with `busy[1]` held. A later `stop[1]` clears it at the next tick.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants: channel count, sound-effect ROM layout tables and the scheduler FSM states.
// Entry i of each table sits at index i (concatenations list channel 7 first).
package audio_pkg;

  localparam int CHANNELS = 8;
  localparam int SFX_AW   = 12;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    COMMIT
  } sfx_state_t;

  localparam logic [CHANNELS-1:0][SFX_AW-1:0] SFX_BASE = {
    12'h700, 12'h600, 12'h500, 12'h400, 12'h300, 12'h200, 12'h100, 12'h000
  };

  localparam logic [CHANNELS-1:0][SFX_AW-1:0] SFX_LEN = {
    12'd7, 12'd2, 12'd8, 12'd5, 12'd6, 12'd12, 12'd3, 12'd4
  };

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a 1-cycle tick every TICK_DIV clocks (tick on the wrap count).
module sample_tick_gen #(
  parameter int TICK_DIV = 3125
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Round-robin sound-effect sequencer: one shared sync ROM, 8 voices, atomic per-tick commit to the mixer.
// Define SFX_LOOP_EN to add the per-channel loop input (looping voices end only on stop).
module sfx_scheduler #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = audio_pkg::CHANNELS,
  parameter int ADDR_W   = 12,
  parameter int TICK_DIV = 3125
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS-1:0]       stop,
`ifdef SFX_LOOP_EN
  input  logic [CHANNELS-1:0]       loop,
`endif
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [WIDTH-1:0]          rom_data,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       busy,
  output logic                      sample_valid
);

  localparam int SW = $clog2(CHANNELS);

  audio_pkg::sfx_state_t r_state, w_state_next;
  logic [SW-1:0]         r_slot;
  logic                  w_tick, w_apply;
  logic                  r_cap_vld, r_cap_busy;
  logic [SW-1:0]         r_cap_slot;
  logic [CHANNELS-1:0]   r_pend_trig, r_pend_stop, w_req_trig, w_req_stop;
  logic [CHANNELS-1:0]   w_busy, w_loop;
  logic [ADDR_W-1:0]     w_offset [CHANNELS];

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

`ifdef SFX_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = '0;
`endif

  // Requests seen in the tick cycle itself are applied with the pending ones.
  assign w_apply    = (r_state == audio_pkg::IDLE) && w_tick;
  assign w_req_trig = r_pend_trig | trigger;
  assign w_req_stop = r_pend_stop | stop;
  assign busy       = w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_trig <= '0;
      r_pend_stop <= '0;
    end else if (w_apply) begin
      r_pend_trig <= '0;
      r_pend_stop <= '0;
    end else begin
      r_pend_trig <= w_req_trig;
      r_pend_stop <= w_req_stop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= audio_pkg::IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= (r_state == audio_pkg::SWEEP) ? r_slot + SW'(1) : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      audio_pkg::IDLE:   if (w_tick) w_state_next = audio_pkg::SWEEP;
      audio_pkg::SWEEP:  if (r_slot == SW'(CHANNELS - 1)) w_state_next = audio_pkg::DRAIN;
      audio_pkg::DRAIN:  w_state_next = audio_pkg::COMMIT;
      default:           w_state_next = audio_pkg::IDLE;
    endcase
  end

  always_comb begin
    rom_en       = 1'b0;
    rom_addr     = '0;
    sample_valid = (r_state == audio_pkg::COMMIT);
    if ((r_state == audio_pkg::SWEEP) && w_busy[r_slot]) begin
      rom_en   = 1'b1;
      rom_addr = ADDR_W'(audio_pkg::SFX_BASE[r_slot]) + w_offset[r_slot];
    end
  end

  // ROM data lags the address by one cycle, so remember which slot it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld  <= 1'b0;
      r_cap_busy <= 1'b0;
      r_cap_slot <= '0;
    end else begin
      r_cap_vld  <= (r_state == audio_pkg::SWEEP);
      r_cap_busy <= rom_en;
      r_cap_slot <= r_slot;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic              r_busy, w_cap, w_last;
    logic [ADDR_W-1:0] r_offset;
    logic [WIDTH-1:0]  r_shadow, r_out, w_shadow_next;

    assign w_cap         = r_cap_vld && (r_cap_slot == SW'(gi));
    assign w_last        = (r_offset == ADDR_W'(audio_pkg::SFX_LEN[gi] - 1'b1));
    assign w_shadow_next = !w_cap ? r_shadow : (r_cap_busy ? rom_data : '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_busy   <= 1'b0;
        r_offset <= '0;
        r_shadow <= '0;
        r_out    <= '0;
      end else begin
        r_shadow <= w_shadow_next;
        // DRAIN's capture is the last one, so the bypassed value completes the frame.
        if (r_state == audio_pkg::DRAIN) r_out <= w_shadow_next;
        if (w_apply) begin
          if (w_req_stop[gi]) begin
            r_busy <= 1'b0;
          end else if (w_req_trig[gi]) begin
            r_busy   <= 1'b1;
            r_offset <= '0;
          end
        end else if (w_cap && r_cap_busy) begin
          if (w_last) begin
            r_offset <= '0;
            r_busy   <= w_loop[gi];
          end else begin
            r_offset <= r_offset + ADDR_W'(1);
          end
        end
      end
    end

    assign w_busy[gi]                   = r_busy;
    assign w_offset[gi]                 = r_offset;
    assign ch_data[gi*WIDTH +: WIDTH]   = r_out;
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler: directed table, hand-written corner sequences and random frames
// checked against a frame-level voice model (covers SFX_LOOP_EN when that macro is defined).
`timescale 1ns/1ps
module tb_sfx_scheduler;
  import audio_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int AW = 12;
  localparam int TD = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   trigger = '0;
  logic [N-1:0]   stop = '0;
  logic [N-1:0]   loop_r = '0;
  logic           rom_en;
  logic [AW-1:0]  rom_addr;
  logic [W-1:0]   rom_data = '0;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   busy;
  logic           sample_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfx_scheduler #(.WIDTH(W), .CHANNELS(N), .ADDR_W(AW), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .stop         (stop),
`ifdef SFX_LOOP_EN
    .loop         (loop_r),
`endif
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ch_data      (ch_data),
    .busy         (busy),
    .sample_valid (sample_valid)
  );

  // ROM content: channel nibble and low offset nibble, plus one, so every sample is non-zero.
  function automatic logic [W-1:0] rom_val(input logic [AW-1:0] a);
    return {a[11:8], a[3:0]} + 8'd1;
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_val(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level voice model.
  bit             m_busy [N];
  int             m_pos  [N];
  logic [N-1:0]   carry_t = '0, carry_s = '0;
  logic [N*W-1:0] exp_data;
  logic [N-1:0]   exp_busy;
  int             exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_busy[c] = 1'b0;
      m_pos[c]  = 0;
    end
    carry_t = '0;
    carry_s = '0;
  endtask

  task automatic model_frame(input logic [N-1:0] t, input logic [N-1:0] s);
    int a;
    exp_q.delete();
    exp_data = '0;
    for (int c = 0; c < N; c++) begin
      if (s[c]) m_busy[c] = 1'b0;
      else if (t[c]) begin
        m_busy[c] = 1'b1;
        m_pos[c]  = 0;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (m_busy[c]) begin
        a = int'(SFX_BASE[c]) + m_pos[c];
        exp_q.push_back(((9 - c) << 16) | a);
        exp_data[c*W +: W] = rom_val(AW'(a));
        if (m_pos[c] == int'(SFX_LEN[c]) - 1) begin
          m_pos[c]  = 0;
          m_busy[c] = loop_r[c];
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
      end
    end
    for (int c = 0; c < N; c++) exp_busy[c] = m_busy[c];
  endtask

  // Requests A are driven at cycle d (before the tick), B at cycle e (during the sweep, deferred).
  task automatic run_frame(input logic [N-1:0] ta, input logic [N-1:0] sa,
                           input logic [N-1:0] tq, input logic [N-1:0] sq,
                           input int d, input int e, input int exp_vcyc, input string tag);
    int vcyc;
    int cyc_q[$];
    int addr_q[$];
    vcyc = -1;
    model_frame(ta | carry_t, sa | carry_s);
    carry_t = tq;
    carry_s = sq;
    for (int cyc = 0; cyc < 48 && vcyc < 0; cyc++) begin
      trigger = (cyc == d) ? ta : '0;
      stop    = (cyc == d) ? sa : '0;
      if (cyc == e) begin
        trigger = trigger | tq;
        stop    = stop | sq;
      end
      @(posedge clk); #1;
      trigger = '0;
      stop    = '0;
      if (rom_en) begin
        cyc_q.push_back(cyc + 1);
        addr_q.push_back(int'(rom_addr));
      end
      if (sample_valid) vcyc = cyc + 1;
    end
    check({tag, " period"}, 64'(vcyc), 64'(exp_vcyc));
    check({tag, " ch_data"}, ch_data, exp_data);
    check({tag, " busy"}, busy, exp_busy);
    check({tag, " rom_count"}, addr_q.size(), exp_q.size());
    for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++)
      check({tag, " rom_addr"}, ((vcyc - cyc_q[i]) << 16) | addr_q[i], exp_q[i]);
    $display("frame %s: ch_data=%h busy=%h reads=%0d", tag, ch_data, busy, addr_q.size());
  endtask

  typedef struct {
    logic [N-1:0]   trig;
    logic [N-1:0]   stp;
    logic [N*W-1:0] data;
    logic [N-1:0]   bsy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ta, sa, tq, sq;

    tbl[0]  = '{8'h01, 8'h00, 64'h01, 8'h01};
    tbl[1]  = '{8'h00, 8'h00, 64'h02, 8'h01};
    tbl[2]  = '{8'h00, 8'h00, 64'h03, 8'h01};
    tbl[3]  = '{8'h00, 8'h00, 64'h04, 8'h00};
    tbl[4]  = '{8'h00, 8'h00, 64'h00, 8'h00};
    tbl[5]  = '{8'h08, 8'h08, 64'h00, 8'h00};
    tbl[6]  = '{8'h04, 8'h00, 64'h21_0000, 8'h04};
    tbl[7]  = '{8'h00, 8'h00, 64'h22_0000, 8'h04};
    tbl[8]  = '{8'h00, 8'h00, 64'h23_0000, 8'h04};
    tbl[9]  = '{8'h00, 8'h00, 64'h24_0000, 8'h04};
    tbl[10] = '{8'h00, 8'h00, 64'h25_0000, 8'h04};
    tbl[11] = '{8'h04, 8'h00, 64'h21_0000, 8'h04};
    tbl[12] = '{8'h00, 8'h04, 64'h00, 8'h00};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset ch_data", ch_data, 0);
    check("reset busy", busy, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset rom_en", rom_en, 0);
    check("reset rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame('0, '0, '0, '0, -1, -1, TD - 1 + 10, "first");

    for (int i = 0; i < 13; i++) begin
      run_frame(tbl[i].trig, tbl[i].stp, '0, '0, 0, -1, TD, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_data", i), ch_data, tbl[i].data);
      check($sformatf("vec%0d tbl_busy", i), busy, tbl[i].bsy);
    end

    run_frame(8'hFF, '0, '0, '0, 0, -1, TD, "all_ch");
    run_frame('0, 8'hFF, '0, '0, 3, -1, TD, "stop_all");

    for (int i = 0; i < 40; i++) begin
      ta = 8'($urandom & $urandom);
      sa = 8'($urandom & $urandom & $urandom);
      tq = (i == 39) ? '0 : 8'($urandom & $urandom);
      sq = (i == 39) ? '0 : 8'($urandom & $urandom & $urandom);
      run_frame(ta, sa, tq, sq, $urandom_range(0, 5), $urandom_range(7, 15), TD,
                $sformatf("rand%0d", i));
    end

    run_frame(8'hFF, '0, '0, '0, 0, -1, TD, "pre_rst");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_sweep rom_en", rom_en, m_busy[3]);
    rst = 1'b1;
    #1;
    check("mid_rst ch_data", ch_data, 0);
    check("mid_rst busy", busy, 0);
    check("mid_rst rom_en", rom_en, 0);
    check("mid_rst rom_addr", rom_addr, 0);
    check("mid_rst sample_valid", sample_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_frame('0, '0, '0, '0, -1, -1, TD - 1 + 10, "post_rst");
    run_frame(8'h01, '0, '0, '0, 2, -1, TD, "post_rst_trig");

`ifdef SFX_LOOP_EN
    loop_r = 8'h02;
    run_frame(8'h02, '0, '0, '0, 0, -1, TD, "loop_start");
    for (int i = 0; i < 5; i++) run_frame('0, '0, '0, '0, -1, -1, TD, $sformatf("loop_run%0d", i));
    run_frame('0, 8'h02, '0, '0, 0, -1, TD, "loop_stop");
    loop_r = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
